// File: rtl/writeback_unit_pkg.sv
// Shared types and widths for the register-file writeback path.
package writeback_unit_pkg;

  localparam int DATA_W             = 32;
  localparam int ADDR_W             = 5;
  localparam int DEFAULT_FIFO_DEPTH = 2;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_t;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_unit_if.sv
// Producer handshakes, regfile write port and decode forwarding lookup.
interface writeback_unit_if;
  import writeback_unit_pkg::*;

  // Each producer transfers on a posedge where valid && ready; ready depends
  // only on registered queue state, and data is ignored without a transfer.
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;

  logic              writeEnable;
  logic [ADDR_W-1:0] writeAddr;
  logic [DATA_W-1:0] writeData;

  logic [ADDR_W-1:0] fwdAddrA;
  logic [ADDR_W-1:0] fwdAddrB;
  logic              fwdHitA;
  logic              fwdHitB;
  logic [DATA_W-1:0] fwdDataA;
  logic [DATA_W-1:0] fwdDataB;

  src_t              dbg_last_grant;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  fwdAddrA, fwdAddrB,
    output alu_ready, mem_ready,
    output writeEnable, writeAddr, writeData,
    output fwdHitA, fwdHitB, fwdDataA, fwdDataB,
    output dbg_last_grant
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output fwdAddrA, fwdAddrB,
    input  alu_ready, mem_ready,
    input  writeEnable, writeAddr, writeData,
    input  fwdHitA, fwdHitB, fwdDataA, fwdDataB,
    input  dbg_last_grant
  );

endinterface

// File: rtl/writeback_unit_wb_fifo.sv
// Synchronous FIFO with extra-bit pointers; push is ignored when full.
module writeback_unit_wb_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = logic
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output entry_t head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  entry_t         mem_q [DEPTH];
  logic           push_ok;
  logic           pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  // A full queue refuses a push even in a cycle where it also pops.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/writeback_unit.sv
// Collects ALU and load results, arbitrates fairly, drives the registered
// regfile write port and a same-cycle forwarding lookup for decode.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input logic             clk,
  input logic             rst,
  writeback_unit_if.slave wb
);

  logic      alu_full, alu_empty, alu_push, alu_pop;
  logic      mem_full, mem_empty, mem_push, mem_pop;
  wb_entry_t alu_in, mem_in, alu_head, mem_head;

  src_t              grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  assign wb.alu_ready = !alu_full;
  assign wb.mem_ready = !mem_full;

  // x0 writes complete their handshake but never reach a queue.
  assign alu_push = wb.alu_valid && !alu_full && (wb.alu_rd != '0);
  assign mem_push = wb.mem_valid && !mem_full && (wb.mem_rd != '0);
  assign alu_in   = '{rd: wb.alu_rd, data: wb.alu_data};
  assign mem_in   = '{rd: wb.mem_rd, data: wb.mem_data};

  writeback_unit_wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(wb_entry_t)) u_alu_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (alu_push),
    .push_data_i(alu_in),
    .pop_i      (alu_pop),
    .full_o     (alu_full),
    .empty_o    (alu_empty),
    .head_o     (alu_head)
  );

  writeback_unit_wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(wb_entry_t)) u_mem_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (mem_push),
    .push_data_i(mem_in),
    .pop_i      (mem_pop),
    .full_o     (mem_full),
    .empty_o    (mem_empty),
    .head_o     (mem_head)
  );

  always_comb begin
    alu_pop = 1'b0;
    mem_pop = 1'b0;
    grant_d = grant_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    // Under contention the source that did not win last time goes first.
    if (!alu_empty && !mem_empty) begin
      if (grant_q == SRC_ALU) mem_pop = 1'b1;
      else                    alu_pop = 1'b1;
    end else if (!alu_empty) begin
      alu_pop = 1'b1;
    end else if (!mem_empty) begin
      mem_pop = 1'b1;
    end
    if (alu_pop) begin
      grant_d = SRC_ALU;
      we_d    = 1'b1;
      waddr_d = alu_head.rd;
      wdata_d = alu_head.data;
    end else if (mem_pop) begin
      grant_d = SRC_MEM;
      we_d    = 1'b1;
      waddr_d = mem_head.rd;
      wdata_d = mem_head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= SRC_ALU;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      grant_q <= grant_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign wb.writeEnable    = we_q;
  assign wb.writeAddr      = waddr_q;
  assign wb.writeData      = wdata_q;
  assign wb.dbg_last_grant = grant_q;

  // The regfile still returns the old value during the commit cycle.
  assign wb.fwdHitA  = we_q && (wb.fwdAddrA == waddr_q) && (wb.fwdAddrA != '0);
  assign wb.fwdHitB  = we_q && (wb.fwdAddrB == waddr_q) && (wb.fwdAddrB != '0);
  assign wb.fwdDataA = wb.fwdHitA ? wdata_q : '0;
  assign wb.fwdDataB = wb.fwdHitB ? wdata_q : '0;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed vectors, per-source expected
// queues popped by a commit monitor.
module tb_writeback_unit;
  import writeback_unit_pkg::*;

  localparam int EW = ADDR_W + DATA_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  writeback_unit_if bus();

  writeback_unit #(.FIFO_DEPTH(DEFAULT_FIFO_DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .wb (bus)
  );

  int checks = 0;
  int errors = 0;
  int commits = 0;

  logic [EW-1:0] alu_exp_q[$];
  logic [EW-1:0] mem_exp_q[$];
  src_t          commit_src_log[$];
  logic [ADDR_W-1:0] commit_rd_log[$];
  logic [EW-1:0] mon_got;

  logic a_acc, m_acc;
  logic alu_stalled, mem_stalled;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every commit must match the head of one source queue
  always @(negedge clk) begin
    if (bus.writeEnable === 1'b1) begin
      mon_got = {bus.writeAddr, bus.writeData};
      commits++;
      checks++;
      if (alu_exp_q.size() > 0 && alu_exp_q[0] == mon_got) begin
        void'(alu_exp_q.pop_front());
        commit_src_log.push_back(SRC_ALU);
      end else if (mem_exp_q.size() > 0 && mem_exp_q[0] == mon_got) begin
        void'(mem_exp_q.pop_front());
        commit_src_log.push_back(SRC_MEM);
      end else begin
        errors++;
        $display("FAIL sb_commit actual=0x%0h required=head of alu or mem expected queue", mon_got);
      end
      commit_rd_log.push_back(bus.writeAddr);
    end
  end

  // driver: one cycle of producer stimulus; expected entries pushed on transfer
  task automatic drive(input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] adat,
                       input logic mv, input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] mdat,
                       output logic aacc, output logic macc);
    @(negedge clk);
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = adat;
    bus.mem_valid = mv;
    bus.mem_rd    = mrd;
    bus.mem_data  = mdat;
    #1;
    aacc = av && bus.alu_ready;
    macc = mv && bus.mem_ready;
    if (av && !bus.alu_ready) alu_stalled = 1'b1;
    if (mv && !bus.mem_ready) mem_stalled = 1'b1;
    if (aacc && ard != '0) alu_exp_q.push_back({ard, adat});
    if (macc && mrd != '0) mem_exp_q.push_back({mrd, mdat});
    @(posedge clk);
    #1;
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((alu_exp_q.size() + mem_exp_q.size()) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(name, 64'(alu_exp_q.size() + mem_exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ai, mi, cyc, base;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.fwdAddrA  = '0;   bus.fwdAddrB = '0;
    alu_stalled = 1'b0; mem_stalled = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst_we",    bus.writeEnable, 1'b0);
    check("rst_addr",  bus.writeAddr, '0);
    check("rst_data",  bus.writeData, '0);
    check("rst_alu_ready", bus.alu_ready, 1'b1);
    check("rst_mem_ready", bus.mem_ready, 1'b1);
    check("rst_last_grant", bus.dbg_last_grant, SRC_ALU);

    // 1: single ALU transfer, commit exactly in cycle t+2
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, a_acc, m_acc);
    check("t1_accept", a_acc, 1'b1);
    @(negedge clk);
    check("t1_we_t1", bus.writeEnable, 1'b0);
    check("t1_ready_t1", bus.alu_ready, 1'b1);
    @(negedge clk);
    check("t1_we_t2", bus.writeEnable, 1'b1);
    check("t1_addr_t2", bus.writeAddr, 5'd5);
    check("t1_data_t2", bus.writeData, 32'hDEADBEEF);
    check("t1_ready_t2", bus.alu_ready, 1'b1);
    @(negedge clk);
    check("t1_we_t3", bus.writeEnable, 1'b0);
    check("t1_hold_addr", bus.writeAddr, 5'd5);

    // 2: x0 load result completes handshake, never writes
    drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234, a_acc, m_acc);
    check("t2_accept", m_acc, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t2_we_idle", bus.writeEnable, 1'b0);
    end

    // 3: simultaneous pushes after reset, alternating commits
    @(negedge clk); rst = 1'b1;
    @(posedge clk); @(negedge clk); rst = 1'b0;
    commit_src_log.delete(); commit_rd_log.delete();
    ai = 0; mi = 0; cyc = 0;
    while ((ai < 5 || mi < 5) && cyc < 100) begin
      drive(ai < 5, ADDR_W'(1 + 2 * ai), 32'h11 + 32'h100 * ai,
            mi < 5, ADDR_W'(2 + 2 * mi), 32'h22 + 32'h100 * mi, a_acc, m_acc);
      if (a_acc) ai++;
      if (m_acc) mi++;
      cyc++;
    end
    wait_drain("t3_drain");
    check("t3_commit_count", commit_src_log.size(), 10);
    if (commit_rd_log.size() >= 2) begin
      check("t3_first_rd", commit_rd_log[0], 5'd2);
      check("t3_second_rd", commit_rd_log[1], 5'd1);
    end
    for (int i = 0; i < commit_src_log.size(); i++)
      check("t3_alternate", commit_src_log[i], (i % 2 == 0) ? SRC_MEM : SRC_ALU);

    // 4: both producers valid every cycle for 20 cycles, backpressure
    alu_stalled = 1'b0; mem_stalled = 1'b0;
    base = commits;
    ai = 0; mi = 0;
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, ADDR_W'((ai * 3) % 31 + 1), 32'hA000_0000 + ai,
            1'b1, ADDR_W'((mi * 7) % 31 + 1), 32'hB000_0000 + mi, a_acc, m_acc);
      if (a_acc) ai++;
      if (m_acc) mi++;
    end
    wait_drain("t4_drain");
    check("t4_alu_backpressure", alu_stalled, 1'b1);
    check("t4_mem_backpressure", mem_stalled, 1'b1);
    check("t4_commit_count", commits - base, ai + mi);

    // 5: forwarding during and after a commit
    drive(1'b1, 5'd7, 32'h55, 1'b0, '0, '0, a_acc, m_acc);
    @(negedge clk);
    @(negedge clk);
    bus.fwdAddrA = 5'd7;
    bus.fwdAddrB = 5'd0;
    #1;
    check("t5_we", bus.writeEnable, 1'b1);
    check("t5_hitA", bus.fwdHitA, 1'b1);
    check("t5_dataA", bus.fwdDataA, 32'h55);
    check("t5_hitB", bus.fwdHitB, 1'b0);
    check("t5_dataB", bus.fwdDataB, 32'h0);
    @(negedge clk);
    #1;
    check("t5_hitA_idle", bus.fwdHitA, 1'b0);
    check("t5_dataA_idle", bus.fwdDataA, 32'h0);
    bus.fwdAddrA = '0;

    // 6: reset with both queues loaded discards everything
    for (int c = 0; c < 4; c++)
      drive(1'b1, ADDR_W'(10 + c), 32'hC000_0000 + c, 1'b1, ADDR_W'(20 + c), 32'hD000_0000 + c, a_acc, m_acc);
    @(negedge clk);
    #2;
    rst = 1'b1;
    alu_exp_q.delete();
    mem_exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("t6_we_after_rst", bus.writeEnable, 1'b0);
    check("t6_alu_ready", bus.alu_ready, 1'b1);
    check("t6_mem_ready", bus.mem_ready, 1'b1);
    #2;
    rst = 1'b0;
    base = commits;
    repeat (10) @(negedge clk);
    check("t6_no_stale_write", commits - base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
